// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling from a baud counter,
// one-cycle done / framing-error strobes, and the last good byte held on RX_DATA.
module uart_rx #(
    parameter int unsigned FREQ     = 100000000,
    parameter int unsigned BAUDRATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RX_Serial,
    output logic [7:0] RX_DATA,
    output logic       RX_DONE,
    output logic       RX_BUSY,
    output logic       RX_FERR
);

    localparam int unsigned DIV  = FREQ / BAUDRATE;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = ($clog2(DIV) > 14) ? $clog2(DIV) : 14;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;

    // Two-flop synchronizer; idle-high reset so reset release never looks like a start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_Serial;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM; the counter is cleared on every state entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            RX_DATA <= 8'h00;
            RX_DONE <= 1'b0;
            RX_BUSY <= 1'b0;
            RX_FERR <= 1'b0;
        end else begin
            RX_DONE <= 1'b0;
            RX_FERR <= 1'b0;
            case (state)
                IDLE: begin
                    RX_BUSY <= 1'b0;
                    cnt     <= '0;
                    if (!rx_s) begin
                        state   <= START;
                        RX_BUSY <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CW'(HALF - 1)) begin
                        cnt <= '0;
                        idx <= '0;
                        // A line that is high again at mid start bit was a glitch
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state   <= IDLE;
                            RX_BUSY <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CW'(DIV - 1)) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    // Leaving mid stop bit lets an immediately following start bit be caught
                    if (cnt == CW'(DIV - 1)) begin
                        cnt <= '0;
                        if (rx_s) begin
                            RX_DATA <= shift;
                            RX_DONE <= 1'b1;
                            RX_BUSY <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            RX_FERR <= 1'b1;
                            state   <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state   <= IDLE;
                        RX_BUSY <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    RX_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV=10: scoreboard of expected bytes against
// bytes captured on RX_DONE, plus framing, glitch, reset and baud-tolerance scenarios.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       rx_ferr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int busy_cnt = 0;
    int both_cnt = 0;
    int rd_ptr = 0;
    logic [7:0] got_mem [256];
    logic [7:0] exp_q [$];

    uart_rx #(.FREQ(1000000), .BAUDRATE(100000)) dut (
        .clk      (clk),
        .reset    (reset),
        .RX_Serial(rx),
        .RX_DATA  (rx_data),
        .RX_DONE  (rx_done),
        .RX_BUSY  (rx_busy),
        .RX_FERR  (rx_ferr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rx_busy) busy_cnt++;
        if (rx_ferr) ferr_cnt++;
        if (rx_done && rx_ferr) both_cnt++;
        if (rx_done) begin
            got_mem[done_cnt[7:0]] = rx_data;
            done_cyc = cyc;
            done_cnt++;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned bn);
        @(posedge clk); #1;
        rx = 1'b0;
        start_cyc = cyc;
        #(bn);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bn);
        end
        rx = stop;
        #(bn);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 3000 && done_cnt < target; i++) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL reset_done: got %0d want 0", done_cnt); end
        n_cmp++; if (ferr_cnt !== 0) begin n_err++; $display("FAIL reset_ferr: got %0d want 0", ferr_cnt); end
        n_cmp++; if (busy_cnt !== 0) begin n_err++; $display("FAIL reset_busy_cycles: got %0d want 0", busy_cnt); end
        n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", rx_data); end
    endtask

    task automatic test_single;
        int d0;
        int lat;
        logic [7:0] e;
        d0 = done_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 100);
        wait_done(d0 + 1);
        lat = done_cyc - start_cyc;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL single_pulses: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (lat < 95 || lat > 99) begin n_err++; $display("FAIL single_latency: got %0d want 95..99", lat); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_after: got %b want 0", rx_busy); end
        n_cmp++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", rx_data); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_ptr >= done_cnt) begin
                n_err++; $display("FAIL single_sb: missing byte, want %h", e);
            end else begin
                if (got_mem[rd_ptr[7:0]] !== e) begin n_err++; $display("FAIL single_sb: got %h want %h", got_mem[rd_ptr[7:0]], e); end
                rd_ptr++;
            end
        end
    endtask

    task automatic test_back_to_back;
        int d0;
        logic [7:0] e;
        logic [7:0] bytes [3];
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(bytes[i]);
            send_frame(bytes[i], 1'b1, 100);
        end
        wait_done(d0 + 3);
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (done_cnt - d0 !== 3) begin n_err++; $display("FAIL b2b_pulses: got %0d want 3", done_cnt - d0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_ptr >= done_cnt) begin
                n_err++; $display("FAIL b2b_sb: missing byte, want %h", e);
            end else begin
                if (got_mem[rd_ptr[7:0]] !== e) begin n_err++; $display("FAIL b2b_sb: got %h want %h", got_mem[rd_ptr[7:0]], e); end
                rd_ptr++;
            end
        end
    endtask

    task automatic test_framing;
        int d0;
        int f0;
        logic [7:0] e;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 100);
        repeat (40) @(posedge clk);
        #1;
        n_cmp++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt - f0); end
        n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL ferr_busy_low_line: got %b want 1", rx_busy); end
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy_released: got %b want 0", rx_busy); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL ferr_no_done: got %0d want 0", done_cnt - d0); end
        n_cmp++; if (rx_data !== 8'h55) begin n_err++; $display("FAIL ferr_data_kept: got %h want 55", rx_data); end
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 100);
        wait_done(d0 + 1);
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_follow_ferr: got %0d want 1", ferr_cnt - f0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_ptr >= done_cnt) begin
                n_err++; $display("FAIL ferr_follow_sb: missing byte, want %h", e);
            end else begin
                if (got_mem[rd_ptr[7:0]] !== e) begin n_err++; $display("FAIL ferr_follow_sb: got %h want %h", got_mem[rd_ptr[7:0]], e); end
                rd_ptr++;
            end
        end
    endtask

    task automatic test_glitch;
        int d0;
        int f0;
        int b0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        b0 = busy_cnt;
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (busy_cnt - b0 < 4 || busy_cnt - b0 > 6) begin n_err++; $display("FAIL glitch_busy_cycles: got %0d want 4..6", busy_cnt - b0); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_after: got %b want 0", rx_busy); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL glitch_done: got %0d want 0", done_cnt - d0); end
        n_cmp++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - f0); end
    endtask

    task automatic test_reset_mid_frame;
        int unsigned bns [3];
        int d0;
        int f0;
        logic [7:0] e;
        bns[0] = 100; bns[1] = 98; bns[2] = 102;
        for (int k = 0; k < 3; k++) begin
            d0 = done_cnt;
            f0 = ferr_cnt;
            fork
                send_frame(8'hC3, 1'b1, bns[k]);
                begin
                    #(bns[k] * 5 + bns[k] / 2);
                    reset = 1'b1;
                end
            join
            @(posedge clk); #1;
            n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rst_mid_data[%0d]: got %h want 00", k, rx_data); end
            n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy[%0d]: got %b want 0", k, rx_busy); end
            repeat (10) @(posedge clk);
            #1 reset = 1'b0;
            repeat (20) @(posedge clk);
            #1;
            n_cmp++; if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin
                n_err++; $display("FAIL rst_mid_pulses[%0d]: got done %0d ferr %0d want 0 0", k, done_cnt - d0, ferr_cnt - f0);
            end
            exp_q.push_back(8'h7E);
            send_frame(8'h7E, 1'b1, bns[k]);
            wait_done(d0 + 1);
            repeat (20) @(posedge clk);
            #1;
            n_cmp++; if (rx_data !== 8'h7E) begin n_err++; $display("FAIL rst_mid_next_data[%0d]: got %h want 7e", k, rx_data); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (rd_ptr >= done_cnt) begin
                    n_err++; $display("FAIL rst_mid_sb[%0d]: missing byte, want %h", k, e);
                end else begin
                    if (got_mem[rd_ptr[7:0]] !== e) begin n_err++; $display("FAIL rst_mid_sb[%0d]: got %h want %h", k, got_mem[rd_ptr[7:0]], e); end
                    rd_ptr++;
                end
            end
        end
    endtask

    task automatic test_exclusive;
        n_cmp++; if (both_cnt !== 0) begin n_err++; $display("FAIL done_ferr_exclusive: got %0d overlaps want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_reset_mid_frame();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
